// File: rtl/shared_div_scheduler.sv
// Shared iterative restoring divider with a round-robin arbiter over the
// per-thread DIV request lines; one quotient/remainder result per grant.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for any req; grants next thread after rr_ptr
// S_DIVIDE | one shift-subtract step per clock, MSB first
// S_DONE   | done[owner_id] high for this cycle, results valid
module shared_div_scheduler #(
   parameter int THREADS   = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [THREADS-1:0]             req,
   input  logic [THREADS*DATA_BITS-1:0]   dividend_flat,
   input  logic [THREADS*DATA_BITS-1:0]   divisor_flat,
   output logic [THREADS-1:0]             done,
   output logic [DATA_BITS-1:0]           quotient,
   output logic [DATA_BITS-1:0]           remainder,
   output logic [$clog2(THREADS)-1:0]     owner_id,
   output logic                           busy
);

   localparam int TW = $clog2(THREADS);
   localparam int SW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        rr_ptr;
   logic [TW-1:0]        grant;
   logic                 grant_vld;
   logic [SW-1:0]        step_q;
   logic [DATA_BITS:0]   rem_acc;
   logic [DATA_BITS-1:0] dvd_q;
   logic [DATA_BITS-1:0] dvs_q;
   logic                 load, step_en, finish;

   logic [DATA_BITS+1:0] trial, diff;
   logic                 ge;
   logic [DATA_BITS:0]   rem_next;
   logic [DATA_BITS-1:0] quo_next;

   // Scan from the far end so the nearest requester after rr_ptr wins last.
   always_comb begin
      grant     = rr_ptr;
      grant_vld = 1'b0;
      for (int k = THREADS; k >= 1; k--) begin
         if (req[(int'(rr_ptr) + k) % THREADS]) begin
            grant     = TW'((int'(rr_ptr) + k) % THREADS);
            grant_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step_en = 1'b0;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               load    = 1'b1;
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            step_en = 1'b1;
            if (step_q == SW'(DATA_BITS - 1)) begin
               finish  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   // Borrow out of the wide subtract doubles as the restoring compare.
   always_comb begin
      trial    = {rem_acc, dvd_q[DATA_BITS-1]};
      diff     = trial - {2'b00, dvs_q};
      ge       = ~diff[DATA_BITS+1];
      rem_next = ge ? diff[DATA_BITS:0] : trial[DATA_BITS:0];
      quo_next = {dvd_q[DATA_BITS-2:0], ge};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= TW'(THREADS - 1);
         owner_id  <= '0;
         step_q    <= '0;
         rem_acc   <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         done      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= '0;
         if (load) begin
            owner_id <= grant;
            rr_ptr   <= grant;
            dvd_q    <= dividend_flat[int'(grant)*DATA_BITS +: DATA_BITS];
            dvs_q    <= divisor_flat[int'(grant)*DATA_BITS +: DATA_BITS];
            rem_acc  <= '0;
            step_q   <= '0;
         end
         if (step_en) begin
            rem_acc <= rem_next;
            dvd_q   <= quo_next;
            step_q  <= step_q + SW'(1);
         end
         if (finish) begin
            done      <= THREADS'(1) << owner_id;
            quotient  <= quo_next;
            remainder <= rem_next[DATA_BITS-1:0];
         end
      end
   end

endmodule

// File: tb/tb_shared_div_scheduler.sv
// Bench for shared_div_scheduler: transaction-level reference model plus
// per-scenario tasks with inline checks.
module tb_shared_div_scheduler;

   localparam int T  = 4;
   localparam int D  = 8;
   localparam int TW = $clog2(T);

   logic             clk = 1'b0;
   logic             reset;
   logic [T-1:0]     req;
   logic [D-1:0]     a [T];
   logic [D-1:0]     b [T];
   logic [T*D-1:0]   dvd_flat, dvs_flat;
   logic [T-1:0]     done;
   logic [D-1:0]     quotient, remainder;
   logic [TW-1:0]    owner_id;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit mon_en = 0;

   for (genvar g = 0; g < T; g++) begin : g_pack
      assign dvd_flat[g*D +: D] = a[g];
      assign dvs_flat[g*D +: D] = b[g];
   end

   shared_div_scheduler #(.THREADS(T), .DATA_BITS(D)) dut (
      .clk(clk), .reset(reset), .req(req),
      .dividend_flat(dvd_flat), .divisor_flat(dvs_flat),
      .done(done), .quotient(quotient), .remainder(remainder),
      .owner_id(owner_id), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: one op occupies D+1 cycles after its grant edge; done in the last.
   int       m_cnt = 0;
   int       m_rr = T - 1;
   int       m_owner = 0;
   logic [D-1:0] m_q = '0, m_r = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt = 0; m_rr = T - 1; m_owner = 0;
      end else if (m_cnt == 0) begin
         for (int k = 1; k <= T; k++)
            if (m_cnt == 0 && req[(m_rr + k) % T]) begin
               m_owner = (m_rr + k) % T;
               m_cnt   = D + 1;
            end
         if (m_cnt != 0) begin
            m_rr = m_owner;
            if (b[m_owner] == 0) begin
               m_q = '1; m_r = a[m_owner];
            end else begin
               m_q = a[m_owner] / b[m_owner];
               m_r = a[m_owner] % b[m_owner];
            end
         end
      end else begin
         m_cnt--;
      end
   end

   // Scoreboard against the model; also plays the requester's req release.
   always @(negedge clk) begin
      logic [T-1:0] ed;
      if (mon_en) begin
         ed = (m_cnt == 1) ? (T'(1) << m_owner) : '0;
         n_checks++;
         if (done !== ed) begin
            n_errors++; $display("FAIL mon_done t=%0t got %b want %b", $time, done, ed);
         end
         n_checks++;
         if (busy !== (m_cnt != 0)) begin
            n_errors++; $display("FAIL mon_busy t=%0t got %b want %b", $time, busy, m_cnt != 0);
         end
         n_checks++;
         if (owner_id !== TW'(m_owner)) begin
            n_errors++; $display("FAIL mon_owner t=%0t got %0d want %0d", $time, owner_id, m_owner);
         end
         if (ed != 0) begin
            n_checks++;
            if (quotient !== m_q || remainder !== m_r) begin
               n_errors++;
               $display("FAIL mon_result t=%0t got q=%0d r=%0d want q=%0d r=%0d",
                        $time, quotient, remainder, m_q, m_r);
            end
            req[m_owner] = 1'b0;
         end
      end
   end

   function automatic int onehot_idx(logic [T-1:0] v);
      for (int i = 0; i < T; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic pulse_reset();
      @(negedge clk); #2 reset = 1'b0;
      @(negedge clk); #2 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; req = '0;
      for (int i = 0; i < T; i++) begin a[i] = '0; b[i] = '0; end
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== '0 || busy !== 1'b0 || owner_id !== '0 ||
          quotient !== '0 || remainder !== '0) begin
         n_errors++;
         $display("FAIL reset_state got done=%b busy=%b own=%0d q=%0d r=%0d want all 0",
                  done, busy, owner_id, quotient, remainder);
      end
      #2 reset = 1'b1;
      mon_en = 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int seen = 0, nb = 0;
      a[0] = 8'd100; b[0] = 8'd7; req = 4'b0001;
      for (int n = 1; n <= 40 && seen == 0; n++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done != 0) begin
            seen = n;
            n_checks++;
            if (done !== 4'b0001 || quotient !== 8'd14 || remainder !== 8'd2 || owner_id !== 2'd0) begin
               n_errors++;
               $display("FAIL single_result got done=%b q=%0d r=%0d own=%0d want 0001 14 2 0",
                        done, quotient, remainder, owner_id);
            end
         end
      end
      n_checks++;
      if (seen != 9) begin
         n_errors++; $display("FAIL single_latency got %0d want 9", seen);
      end
      n_checks++;
      if (nb != 9) begin
         n_errors++; $display("FAIL single_busy_cycles got %0d want 9", nb);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL single_idle got busy=%b want 0", busy);
      end
   endtask

   task automatic test_all_four();
      int ord[$];
      int tcy[$];
      pulse_reset();
      for (int i = 0; i < T; i++) begin
         a[i] = D'($urandom_range(0, 255));
         b[i] = D'($urandom_range(1, 255));
      end
      req = '1;
      for (int n = 0; n < 80 && ord.size() < T; n++) begin
         @(negedge clk);
         if (done != 0) begin ord.push_back(onehot_idx(done)); tcy.push_back(cyc); end
      end
      n_checks++;
      if (ord.size() != T) begin
         n_errors++; $display("FAIL all4_count got %0d want %0d", ord.size(), T);
      end
      for (int i = 0; i < ord.size(); i++) begin
         n_checks++;
         if (ord[i] != i) begin
            n_errors++; $display("FAIL all4_order[%0d] got %0d want %0d", i, ord[i], i);
         end
         if (i > 0) begin
            n_checks++;
            if (tcy[i] - tcy[i-1] != D + 2) begin
               n_errors++; $display("FAIL all4_spacing[%0d] got %0d want %0d", i, tcy[i] - tcy[i-1], D + 2);
            end
         end
      end
   endtask

   task automatic test_div_zero();
      bit seen = 0;
      a[2] = 8'd250; b[2] = 8'd0; req[2] = 1'b1;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (done != 0) begin
            seen = 1;
            n_checks++;
            if (done !== 4'b0100 || quotient !== 8'hFF || remainder !== 8'd250) begin
               n_errors++;
               $display("FAIL div_zero got done=%b q=%0d r=%0d want 0100 255 250", done, quotient, remainder);
            end
         end
      end
      n_checks++;
      if (!seen) begin n_errors++; $display("FAIL div_zero_timeout got no done want done"); end
      @(negedge clk);
   endtask

   task automatic test_rr_rotation();
      int ord[$];
      a[1] = 8'd77; b[1] = 8'd5; req[1] = 1'b1;
      repeat (3) @(negedge clk);
      a[3] = 8'd99; b[3] = 8'd10; req[3] = 1'b1;
      for (int n = 0; n < 100 && ord.size() < 3; n++) begin
         @(negedge clk);
         if (done != 0) begin
            ord.push_back(onehot_idx(done));
            if (ord.size() == 1) begin
               @(negedge clk);
               a[1] = 8'd200; b[1] = 8'd13; req[1] = 1'b1;
            end
         end
      end
      n_checks++;
      if (ord.size() != 3 || ord[0] != 1 || ord[1] != 3 || ord[2] != 1) begin
         n_errors++; $display("FAIL rr_order got %p want '{1,3,1}", ord);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      a[0] = 8'd200; b[0] = 8'd9; req = 4'b0001;
      repeat (6) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (done !== '0 || busy !== 1'b0 || quotient !== '0 || remainder !== '0 || owner_id !== '0) begin
         n_errors++;
         $display("FAIL midreset_zero got done=%b busy=%b q=%0d r=%0d own=%0d want all 0",
                  done, busy, quotient, remainder, owner_id);
      end
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      for (int n = 1; n <= 40 && seen == 0; n++) begin
         @(negedge clk);
         if (done != 0) begin
            seen = n;
            n_checks++;
            if (done !== 4'b0001 || quotient !== 8'd22 || remainder !== 8'd2) begin
               n_errors++;
               $display("FAIL midreset_result got done=%b q=%0d r=%0d want 0001 22 2", done, quotient, remainder);
            end
         end
      end
      n_checks++;
      if (seen != 9) begin n_errors++; $display("FAIL midreset_latency got %0d want 9", seen); end
      @(negedge clk);
   endtask

   task automatic test_edge_cases();
      logic [D-1:0] ta [4] = '{8'd255, 8'd7,   8'd255, 8'd180};
      logic [D-1:0] tb [4] = '{8'd1,   8'd255, 8'd255, 8'd11};
      logic [D-1:0] tq [4] = '{8'd255, 8'd0,   8'd1,   8'd16};
      logic [D-1:0] tr [4] = '{8'd0,   8'd7,   8'd0,   8'd4};
      for (int c = 0; c < 4; c++) begin
         int t = c % T;
         bit seen = 0;
         a[t] = ta[c]; b[t] = tb[c]; req[t] = 1'b1;
         for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == 3) begin a[t] = D'($urandom); b[t] = D'($urandom); end
            if (done != 0) begin
               seen = 1;
               n_checks++;
               if (quotient !== tq[c] || remainder !== tr[c]) begin
                  n_errors++;
                  $display("FAIL edge[%0d] got q=%0d r=%0d want q=%0d r=%0d",
                           c, quotient, remainder, tq[c], tr[c]);
               end
            end
         end
         n_checks++;
         if (!seen) begin n_errors++; $display("FAIL edge_timeout[%0d] got no done want done", c); end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      int ops = 0;
      bit drained = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (done != 0) ops++;
         for (int i = 0; i < T; i++)
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               a[i] = D'($urandom);
               b[i] = ($urandom_range(0, 7) == 0) ? '0 : D'($urandom);
               req[i] = 1'b1;
            end
      end
      for (int n = 0; n < 200 && !drained; n++) begin
         @(negedge clk);
         if (req == '0 && !busy) drained = 1;
      end
      n_checks++;
      if (!drained) begin n_errors++; $display("FAIL random_drain got req=%b busy=%b want idle", req, busy); end
      n_checks++;
      if (ops < 40) begin n_errors++; $display("FAIL random_ops got %0d want >=40", ops); end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_div_zero();
      test_rr_rotation();
      test_reset_mid();
      test_edge_cases();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
